// File: rtl/spi_host_pkg.sv
// spi_host_pkg: FSM state type and frame constants for the SPI host; VERIFY_RD exists only with SPI_HOST_WR_VERIFY_EN
package spi_host_pkg;
  localparam int FRAME_BITS = 16;
  localparam int CMD_RW_BIT = 7;
  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 8;
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
`ifdef SPI_HOST_WR_VERIFY_EN
    , VERIFY_RD
`endif
  } state_e;
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic wr, input logic [ADDR_W-1:0] addr,
                                                       input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] cmd;
    cmd = DATA_W'(addr);
    cmd[CMD_RW_BIT] = wr;
    return {cmd, wr ? data : {DATA_W{1'b0}}};
  endfunction
endpackage

// File: rtl/spi_host_if.sv
// spi_host_if: host-side request/response bus of the SPI host
interface spi_host_if;
  import spi_host_pkg::*;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_mismatch;
  logic              busy;
  modport master (output req_valid, req_write, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_mismatch, busy);
  modport slave  (input  req_valid, req_write, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata, rsp_mismatch, busy);
endinterface

// File: rtl/spi_host_clkgen.sv
// spi_host_clkgen: sclk divider with one-cycle strobes ahead of each sclk rise and fall; held low when disabled
module spi_host_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);
  logic [7:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;
  logic       wrap;
  always_comb begin
    wrap     = cnt_q == 8'(CLK_DIV - 1);
    rise_stb = en && wrap && !sclk_q;
    fall_stb = en && wrap && sclk_q;
    cnt_d    = en && !wrap ? cnt_q + 8'd1 : 8'd0;
    sclk_d   = en && (sclk_q ^ wrap);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end
  assign sclk = sclk_q;
endmodule

// File: rtl/spi_host.sv
// spi_host: mode-0 SPI initiator for single-register reads/writes; SPI_HOST_WR_VERIFY_EN adds an automatic readback after each write
module spi_host
  import spi_host_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  spi_host_if.slave bus,
  output logic      sclk,
  output logic      cs_n,
  output logic      mosi,
  input  logic      miso
);
  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [3:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic [DATA_W-1:0]     rx_q, rx_d, rdata_q, rdata_d;
  logic                  wr_q, wr_d, rsp_q, rsp_d;
  logic                  rise_stb, fall_stb, ready, accept, framing;
`ifdef SPI_HOST_WR_VERIFY_EN
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  mis_q, mis_d, vfy_q, vfy_d;
`endif
  spi_host_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk(clk), .rst_n(rst_n), .en(state_q == SHIFT),
    .sclk(sclk), .rise_stb(rise_stb), .fall_stb(fall_stb)
  );
  assign ready   = (state_q == IDLE) && rst_n;
  assign accept  = bus.req_valid && ready;
  assign framing = state_q == SETUP || state_q == SHIFT || state_q == HOLD;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    rsp_d   = 1'b0;
`ifdef SPI_HOST_WR_VERIFY_EN
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    vfy_d   = vfy_q;
`endif
    case (state_q)
      IDLE: if (accept) begin
        state_d = SETUP;
        cnt_d   = '0;
        sh_d    = make_frame(bus.req_write, bus.req_addr, bus.req_wdata);
        wr_d    = bus.req_write;
`ifdef SPI_HOST_WR_VERIFY_EN
        addr_d  = bus.req_addr;
        wdata_d = bus.req_wdata;
        vfy_d   = 1'b0;
`endif
      end
      SETUP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(CS_SETUP - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = 4'd15;
        end
      end
      SHIFT: begin
        if (rise_stb) rx_d = {rx_q[DATA_W-2:0], miso};
        // the final fall leaves the last bit on mosi through HOLD
        if (fall_stb) begin
          if (bit_q == 4'd0) state_d = HOLD;
          else begin
            bit_d = bit_q - 4'd1;
            sh_d  = {sh_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      HOLD: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(CS_HOLD - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
          rdata_d = wr_q ? '0 : rx_q;
          rsp_d   = 1'b1;
`ifdef SPI_HOST_WR_VERIFY_EN
          rsp_d   = !wr_q;
          mis_d   = vfy_q && (rx_q != wdata_q);
`endif
        end
      end
      GAP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(CLK_DIV - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
`ifdef SPI_HOST_WR_VERIFY_EN
          if (wr_q) state_d = VERIFY_RD;
`endif
        end
      end
`ifdef SPI_HOST_WR_VERIFY_EN
      VERIFY_RD: begin
        state_d = SETUP;
        sh_d    = make_frame(1'b0, addr_q, wdata_q);
        wr_d    = 1'b0;
        vfy_d   = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      rx_q    <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      rsp_q   <= 1'b0;
`ifdef SPI_HOST_WR_VERIFY_EN
      addr_q  <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      vfy_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      rsp_q   <= rsp_d;
`ifdef SPI_HOST_WR_VERIFY_EN
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      vfy_q   <= vfy_d;
`endif
    end
  end
  assign cs_n          = !framing;
  assign mosi          = framing && sh_q[FRAME_BITS-1];
  assign bus.req_ready = ready;
  assign bus.busy      = state_q != IDLE;
  assign bus.rsp_valid = rsp_q;
  assign bus.rsp_rdata = rdata_q;
`ifdef SPI_HOST_WR_VERIFY_EN
  assign bus.rsp_mismatch = mis_q;
`else
  assign bus.rsp_mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_spi_host.sv
// tb_spi_host: randomized bench for two spi_host builds (CLK_DIV 4 and 2) against a frame/response scoreboard
module tb_spi_host;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  typedef struct {int inst; logic [15:0] fr;} fr_t;
  typedef struct {int inst; logic [7:0] rd; logic mm;} rs_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  spi_host_if bus0();
  spi_host_if bus1();
  logic [1:0] sclk, cs_n, mosi, miso, rv, rdy, rspv, mism, busy;
  logic [1:0][7:0] rdat;
  logic       rw;
  logic [5:0] ra;
  logic [7:0] rd;
  assign bus0.req_valid = rv[0];
  assign bus1.req_valid = rv[1];
  assign bus0.req_write = rw;
  assign bus1.req_write = rw;
  assign bus0.req_addr  = ra;
  assign bus1.req_addr  = ra;
  assign bus0.req_wdata = rd;
  assign bus1.req_wdata = rd;
  assign rdy  = {bus1.req_ready, bus0.req_ready};
  assign rspv = {bus1.rsp_valid, bus0.rsp_valid};
  assign mism = {bus1.rsp_mismatch, bus0.rsp_mismatch};
  assign busy = {bus1.busy, bus0.busy};
  assign rdat[0] = bus0.rsp_rdata;
  assign rdat[1] = bus1.rsp_rdata;
  spi_host #(.CLK_DIV(4), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi[0]), .miso(miso[0]));
  spi_host #(.CLK_DIV(2), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .sclk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi[1]), .miso(miso[1]));
  int n_chk = 0;
  int n_err = 0;
  fr_t exp_fr[$];
  rs_t exp_rsp[$];
  logic [15:0] stx[2], srx[2];
  logic [7:0]  slv[2];
  int   srise[2], slow[2], shigh[2], sper[2], gapmin[2], rsp_cnt[2];
  logic pcs[2], psclk[2], seen[2];
  logic quiet = 1'b0;
  int   bad_rdy = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int div(input int i);
    return i == 0 ? 4 : 2;
  endfunction
  function automatic int cs_low_len(input int i);
    return CS_SETUP + 32 * div(i) + CS_HOLD;
  endfunction
  // Reference: each request yields its frame(s) on the wire and exactly one response
  function automatic void expect_txn(input int i, input logic wr, input logic [5:0] addr,
                                     input logic [7:0] wdata, input logic [7:0] sbyte);
    logic ver = 1'b0;
`ifdef SPI_HOST_WR_VERIFY_EN
    ver = wr;
`endif
    exp_fr.push_back('{i, {wr, 1'b0, addr, wr ? wdata : 8'h00}});
    if (ver) begin
      exp_fr.push_back('{i, {2'b00, addr, 8'h00}});
      exp_rsp.push_back('{i, sbyte, sbyte != wdata});
    end else exp_rsp.push_back('{i, wr ? 8'h00 : sbyte, 1'b0});
  endfunction
  task automatic slave_step(input int i);
    fr_t f;
    rs_t r;
    if (!cs_n[i]) begin
      if (pcs[i]) begin
        stx[i] = {8'($urandom), slv[i]};
        srx[i] = '0; srise[i] = 0; slow[i] = 0; sper[i] = 0;
        if (seen[i] && shigh[i] < gapmin[i]) gapmin[i] = shigh[i];
      end
      slow[i]++;
      sper[i]++;
      if (sclk[i] && !psclk[i]) begin
        if (srise[i] > 0 && !quiet) chk("sclk_period", sper[i], 2 * div(i));
        sper[i] = 0;
        srx[i] = {srx[i][14:0], mosi[i]};
        srise[i]++;
      end
      if (!sclk[i] && psclk[i]) stx[i] = {stx[i][14:0], 1'b0};
      miso[i] = stx[i][15];
    end else begin
      shigh[i] = pcs[i] ? shigh[i] + 1 : 1;
      if (!pcs[i] && !quiet) begin
        seen[i] = 1'b1;
        if (exp_fr.size() == 0) chk("frame_unexpected", 1, 0);
        else begin
          f = exp_fr.pop_front();
          chk("frame_inst", i, f.inst);
          chk("mosi_frame", srx[i], f.fr);
          chk("sclk_rises", srise[i], 16);
          chk("cs_low_cycles", slow[i], cs_low_len(i));
        end
      end
    end
    if (rspv[i]) begin
      rsp_cnt[i]++;
      if (exp_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        r = exp_rsp.pop_front();
        chk("rsp_inst", i, r.inst);
        chk("rsp_rdata", rdat[i], r.rd);
        chk("rsp_mismatch", mism[i], r.mm);
      end
    end
    if (busy[i] && rdy[i]) bad_rdy++;
    pcs[i] = cs_n[i];
    psclk[i] = sclk[i];
  endtask
  initial begin
    miso = '0;
    for (int i = 0; i < 2; i++) begin
      pcs[i] = 1'b1; psclk[i] = 1'b0; seen[i] = 1'b0; gapmin[i] = 1000;
      rsp_cnt[i] = 0; shigh[i] = 0; slv[i] = '0; stx[i] = '0; srx[i] = '0;
    end
  end
  always @(negedge clk) begin
    slave_step(0);
    slave_step(1);
  end
  task automatic do_txn(input int i, input logic wr, input logic [5:0] addr, input logic [7:0] wdata,
                        input logic [7:0] sbyte);
    int n, base;
    logic ver = 1'b0;
`ifdef SPI_HOST_WR_VERIFY_EN
    ver = wr;
`endif
    @(negedge clk);
    slv[i] = sbyte;
    expect_txn(i, wr, addr, wdata, sbyte);
    base = rsp_cnt[i];
    rw = wr; ra = addr; rd = wdata; rv[i] = 1'b1;
    n = 0;
    while (!rdy[i] && n < 1000) begin @(negedge clk); n++; end
    chk("accept_timeout", n < 1000, 1);
    @(posedge clk);
    @(negedge clk);
    rv[i] = 1'b0;
    rw = 1'($urandom); ra = 6'($urandom); rd = 8'($urandom);
    n = 1;
    while (!rspv[i] && n < 3000) begin @(negedge clk); n++; end
    chk("rsp_timeout", n < 3000, 1);
    if (!ver) chk("rsp_latency", n, cs_low_len(i) + 1);
    n = 0;
    while (busy[i] && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("rsp_count", rsp_cnt[i] - base, 1);
  endtask
  initial begin
    int n, base;
    logic [7:0] sb;
    logic       bw[3];
    logic [5:0] ba[3];
    logic [7:0] bd[3];
    rv = '0; rw = 1'b0; ra = '0; rd = '0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_sclk", sclk[i], 0);
      chk("rst_cs_n", cs_n[i], 1);
      chk("rst_mosi", mosi[i], 0);
      chk("rst_ready", rdy[i], 0);
      chk("rst_rsp_valid", rspv[i], 0);
      chk("rst_rdata", rdat[i], 0);
      chk("rst_mismatch", mism[i], 0);
      chk("rst_busy", busy[i], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", rdy, 2'b11);
    do_txn(0, 1'b1, 6'h02, 8'h55, 8'h00);
    do_txn(0, 1'b0, 6'h03, 8'h00, 8'hA5);
    do_txn(1, 1'b0, 6'h15, 8'h00, 8'h3C);
    do_txn(0, 1'b1, 6'h04, 8'h10, 8'h11);
    do_txn(0, 1'b1, 6'h04, 8'h10, 8'h10);
    do_txn(1, 1'b1, 6'h3F, 8'hFF, 8'h00);
    // req_valid held across three requests, fields updated after each acceptance
    sb = 8'($urandom);
    slv[0] = sb;
    base = rsp_cnt[0];
    gapmin[0] = 1000;
    bad_rdy = 0;
    for (int k = 0; k < 3; k++) begin
      bw[k] = 1'($urandom); ba[k] = 6'($urandom); bd[k] = 8'($urandom);
      expect_txn(0, bw[k], ba[k], bd[k], sb);
    end
    @(negedge clk);
    rw = bw[0]; ra = ba[0]; rd = bd[0]; rv[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!rdy[0] && n < 2000) begin @(negedge clk); n++; end
      chk("b2b_accept_timeout", n < 2000, 1);
      @(posedge clk);
      @(negedge clk);
      if (k < 2) begin rw = bw[k+1]; ra = ba[k+1]; rd = bd[k+1]; end
      else rv[0] = 1'b0;
    end
    n = 0;
    while ((busy[0] || rsp_cnt[0] - base < 3) && n < 3000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("b2b_rsp_count", rsp_cnt[0] - base, 3);
    chk("b2b_cs_gap_ge4", gapmin[0] >= 4, 1);
    chk("b2b_ready_while_busy", bad_rdy, 0);
    // reset during bit 9 of the shift phase
    base = rsp_cnt[0];
    @(negedge clk);
    slv[0] = 8'h5A;
    expect_txn(0, 1'b0, 6'h09, 8'h00, 8'h5A);
    rw = 1'b0; ra = 6'h09; rv[0] = 1'b1;
    n = 0;
    while (!rdy[0] && n < 1000) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    rv[0] = 1'b0;
    n = 0;
    while (srise[0] < 7 && n < 1000) begin @(negedge clk); n++; end
    chk("bit9_timeout", n < 1000, 1);
    quiet = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sclk", sclk[0], 0);
    chk("midrst_cs_n", cs_n[0], 1);
    chk("midrst_mosi", mosi[0], 0);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_rsp_valid", rspv[0], 0);
    exp_fr.delete();
    exp_rsp.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_no_rsp", rsp_cnt[0] - base, 0);
    chk("midrst_ready", rdy[0], 1);
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    quiet = 1'b0;
    do_txn(0, 1'b0, 6'h09, 8'h00, 8'hC3);
    for (int t = 0; t < 16; t++)
      do_txn(t % 2, 1'($urandom), 6'($urandom), 8'($urandom), 8'($urandom));
    chk("frames_left", exp_fr.size(), 0);
    chk("rsps_left", exp_rsp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/spi_host.md
Name: spi_host

Overview:
- SPI initiator (mode 0, MSB first) that issues single-register read/write transactions to the PWM peripheral's SPI register bridge.
- The host side uses a simple valid/ready request and a one-cycle response pulse; the line side drives sclk, cs_n and mosi, and samples miso.
- Used in system-level benches and in host-side designs that configure the PWM timer over SPI.

Parameters:
- CLK_DIV, 4, sclk half-period in clk cycles; legal range 2..255.
- CS_SETUP, 2, clk cycles from cs_n falling to the first sclk rise; minimum 1.
- CS_HOLD, 2, clk cycles from the last sclk fall to cs_n rising; minimum 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  transaction request
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high
- req_write  in  1  1 = write, 0 = read
- req_addr  in  6  register address
- req_wdata  in  8  write data; ignored for reads
- rsp_valid  out  1  one-cycle pulse at transaction end
- rsp_rdata  out  8  read data; valid while rsp_valid is high; 0x00 after a write
- rsp_mismatch  out  1  write-verify failure flag; valid with rsp_valid
- busy  out  1  high from acceptance until the end of the post-transaction gap
- sclk  out  1  SPI clock; idles low
- cs_n  out  1  chip select, active low
- mosi  out  1  serial data to the peripheral
- miso  in  1  serial data from the peripheral

Behaviour:
- Reset values: sclk=0, cs_n=1, mosi=0, req_ready=0 while in reset and 1 in the first IDLE cycle after reset, rsp_valid=0, rsp_rdata=0x00, rsp_mismatch=0, busy=0.
- Frame format: 16 bits, MSB first.
  - Byte 0 = {req_write, 1'b0, req_addr[5:0]}.
  - Byte 1 = req_wdata for a write, 0x00 for a read.
  - For a read, the peripheral returns data on miso during byte 1.
- Request capture: req_write, req_addr and req_wdata are captured at acceptance. Later input changes have no effect until the next request.
- FSM states and transitions:
  - IDLE -> SETUP on acceptance.
  - SETUP: cs_n=0, mosi=bit15, lasts CS_SETUP cycles, then -> SHIFT.
  - SHIFT: 16 sclk periods of 2*CLK_DIV cycles each. sclk is low for the first CLK_DIV cycles and high for the second.
    - miso is captured on the clk edge that drives sclk 0->1.
    - mosi advances to the next bit on the clk edge that drives sclk 1->0. After the last fall, mosi holds.
  - HOLD: sclk=0, cs_n=0, lasts CS_HOLD cycles, then -> GAP.
  - GAP: cs_n=1, lasts CLK_DIV cycles, then -> IDLE.
- Timing: cs_n is low for exactly CS_SETUP + 32*CLK_DIV + CS_HOLD cycles (132 with defaults).
- Response: rsp_valid pulses in the first GAP cycle, i.e. the cycle cs_n returns to 1. rsp_rdata = the 8 bits sampled during bits 7..0 for a read.
- Back-to-back requests: req_ready is low in every state except IDLE, so a request held valid is accepted in the first IDLE cycle after GAP. There is no request queueing.
- Reset mid-transaction: all outputs return asynchronously to their reset values, the FSM goes to IDLE, and no rsp_valid is generated.
- Counters:
  - The divider counter wraps at CLK_DIV-1.
  - The bit counter is 4 bits and counts 15 down to 0. The SHIFT -> HOLD exit happens on the sclk fall of bit 0.

Optional Feature:
- Macro: SPI_HOST_WR_VERIFY_EN.
- Defined:
  - Each accepted write is followed, after its GAP, by an automatic read of the same address.
  - busy and req_ready stay low (not ready) throughout both transactions.
  - rsp_valid is issued only once, at the end of the read. It carries rsp_rdata = readback and rsp_mismatch = (readback != written data).
  - Reads behave as without the macro.
  - Write-only or self-clearing registers will flag mismatch by design.
- Undefined: no automatic readback; rsp_mismatch is tied to 0.

Decomposition:
- Package spi_host_pkg holds:
  - the FSM state enum (IDLE, SETUP, SHIFT, HOLD, GAP, plus VERIFY_RD under the macro);
  - FRAME_BITS=16, CMD_RW_BIT=7, ADDR_W=6, DATA_W=8.
- Sub-module spi_host_clkgen: the divider that produces sclk plus one-cycle rise_stb and fall_stb strobes. It is enabled only in SHIFT.

Test Plan:
- Write to addr 0x02 with data 0x55 -> mosi bitstream 0x82 then 0x55. cs_n is low for 132 cycles and sclk shows 16 rises. rsp_valid pulses once, with rsp_rdata=0x00.
- Read of addr 0x03 with the slave model driving 0xA5 in byte 1 -> mosi byte 0 = 0x03, byte 1 = 0x00. rsp_rdata=0xA5, arriving 133 cycles after acceptance.
- req_valid held high for 3 requests -> exactly 3 frames. cs_n is high for ≥4 cycles between frames, req_ready is 0 while busy, and there are 3 rsp_valid pulses.
- rst_n asserted during bit 9 of SHIFT -> sclk=0, cs_n=1, mosi=0 immediately. No rsp_valid is generated, and a new request is accepted and completes normally after reset.
- CLK_DIV=2 build: read returning 0x3C -> sclk period of 4 cycles, cs_n low for 68 cycles, rsp_rdata=0x3C.
- With SPI_HOST_WR_VERIFY_EN defined: write 0x10 to addr 0x04 with the slave returning 0x11 -> two frames, a single rsp_valid, rsp_rdata=0x11 and rsp_mismatch=1. Repeat with the slave returning 0x10 -> rsp_mismatch=0.
